sig_sync2async: RTL and testbench
=================================

SIG_SYNC2ASYNC -- requirements
Module: sig_sync2async

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- CNT_W, 4, width of the pending-event counter.
- SYNC_STAGES, 2, depth of the ack synchronizer; legal range 2..4.
- TIMEOUT_CYC, 1024, watchdog limit in sys_clk cycles; used only under the configuration macro.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- sys_clk, input, 1, the single clock; all logic is on its rising edge.
- sys_rst, input, 1, reset; synchronous, active-high.
- sync_done_pulse, input, 1, single-cycle event strobe in the sys_clk domain.
- async_done_ack, input, 1, acknowledge returned by the foreign domain; asynchronous to sys_clk.
- err_clr, input, 1, single-cycle strobe that clears the sticky error flags.
- async_done_req, output, 1, registered request level presented to the foreign domain.
- pend_cnt, output, CNT_W, number of events queued and not yet launched.
- busy, output, 1, high while the FSM is not in IDLE.
- overflow, output, 1, sticky flag: an event was dropped.
- timeout_err, output, 1, sticky flag: the handshake watchdog expired.

Function
REQ-003 The block SHALL pass async_done_ack through SYNC_STAGES flops; only the last stage (ack_s) SHALL be used.
REQ-004 The block SHALL run a 4-phase handshake FSM with the states IDLE, REQ and RELEASE.
REQ-005 In IDLE, if sync_done_pulse=1 or pend_cnt!=0, the FSM SHALL move to REQ, and async_done_req SHALL be 1 from the next edge.
REQ-006 In REQ, async_done_req SHALL be held at 1 until ack_s=1, after which the FSM SHALL move to RELEASE and async_done_req SHALL be 0 from the next edge.
REQ-007 In RELEASE, async_done_req SHALL be held at 0 until ack_s=0, after which the FSM SHALL move to IDLE.
REQ-008 async_done_req SHALL be driven directly by a flop, with no combinational path, so it is glitch-free.
REQ-009 Latency SHALL be one cycle: a pulse on edge N with the FSM in IDLE and pend_cnt=0 raises async_done_req at edge N+1 without incrementing pend_cnt.
REQ-010 pend_cnt SHALL increment on a pulse that is not consumed directly by an IDLE launch.
REQ-011 pend_cnt SHALL decrement on an IDLE launch taken while pend_cnt!=0.
REQ-012 A pulse arriving in the same cycle as a decrementing launch SHALL leave pend_cnt unchanged.
REQ-013 A pulse arriving while pend_cnt is at its maximum (2^CNT_W-1) and no decrement occurs SHALL be dropped, and overflow SHALL be set; pend_cnt SHALL NOT wrap.
REQ-014 An err_clr strobe SHALL clear overflow and timeout_err on the next edge; if a set event occurs in the same cycle, set SHALL win.
REQ-015 busy SHALL be high exactly when the state is REQ or RELEASE.
REQ-016 An ack_s transition in an unexpected state (rising in IDLE or RELEASE) SHALL be ignored.

Reset
REQ-017 While sys_rst=1 on an edge, the block SHALL take: state IDLE, async_done_req 0, pend_cnt 0, busy 0, overflow 0, timeout_err 0, all synchronizer and watchdog flops 0.
REQ-018 A reset asserted mid-handshake SHALL drop async_done_req on that edge and discard all pending events.
REQ-019 Pulses that coincide with reset SHALL be lost.

Configuration
REQ-020 The macro SIG_S2A_TIMEOUT_EN SHALL control the watchdog.
- Defined: a watchdog counts cycles spent in REQ or RELEASE. When the count reaches TIMEOUT_CYC, the FSM SHALL go to IDLE, async_done_req SHALL go to 0, timeout_err SHALL be set, and the watchdog SHALL clear on every state change.
- Undefined: no watchdog logic exists, timeout_err is tied 0, and the TIMEOUT_CYC parameter is unused.

Structure
REQ-021 State encodings (IDLE=2'd0, REQ=2'd1, RELEASE=2'd2) and the default values of CNT_W, SYNC_STAGES and TIMEOUT_CYC SHALL live in the shared package cnnaf_sync_pkg.
REQ-022 The ack synchronizer SHALL be a separate sub-module, sync_ff_chain, parameterised by stage count, with no reset-less flops.
REQ-023 The FSM, counter and watchdog SHALL stay in sig_sync2async.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Single pulse at cycle 10, with ack echoed back 3 cycles after req rises and falls -> req high at cycle 11, one full handshake, pend_cnt stays 0, busy low after ack_s falls.
- Five pulses in consecutive cycles with a slow ack (20 cycles) -> pend_cnt peaks at 4, five complete handshakes, pend_cnt returns to 0.
- With CNT_W=2, 5 pulses sent while the first handshake is stalled -> pend_cnt saturates at 3, overflow=1; err_clr clears it.
- A pulse in the same cycle as an IDLE launch with pend_cnt=2 -> pend_cnt remains 2.
- sys_rst asserted while in REQ -> req=0 and pend_cnt=0 on that edge; a spurious ack afterwards causes no state change.
- With SIG_S2A_TIMEOUT_EN and TIMEOUT_CYC=16, ack never returns -> after 16 cycles in REQ, req=0, timeout_err=1, state IDLE.

Source files
------------

// File: rtl/cnnaf_sync_pkg.sv
// Shared handshake state encodings and parameter defaults for the
// sync-to-async event bridge (sig_sync2async and its ack synchronizer).
package cnnaf_sync_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam int CNT_W_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop level synchronizer for a single asynchronous input; every
// stage is reset so the chain starts from a known low level.
module sync_ff_chain
    import cnnaf_sync_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("sync_ff_chain: STAGES must be in 2..4");
    end

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sig_sync2async.sv
// Bridges single-cycle sys_clk events to a 4-phase req/ack handshake with a
// foreign domain, queueing events that arrive while a handshake is in flight.
// Optional handshake watchdog is enabled by defining SIG_S2A_TIMEOUT_EN.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_IDLE     | no handshake in flight; launches on a pulse or queued event
//   ST_REQ      | req held high, waiting for synchronized ack to rise
//   ST_RELEASE  | req held low, waiting for synchronized ack to fall
module sig_sync2async
    import cnnaf_sync_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             sync_done_pulse,
    input  logic             async_done_ack,
    input  logic             err_clr,
    output logic             async_done_req,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             busy,
    output logic             overflow,
    output logic             timeout_err
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("sig_sync2async: TIMEOUT_CYC must be at least 1");
    end

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             ovf_set;
    logic             ack_s;
    logic             pend_nz;
    logic             launch;
    logic             dec;
    logic             pulse_held;

    sync_ff_chain #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk(sys_clk),
        .rst(sys_rst),
        .d  (async_done_ack),
        .q  (ack_s)
    );

`ifdef SIG_S2A_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_expired;
    logic            tmo_q, tmo_d;

    always_comb begin
        wd_expired = (state_q != ST_IDLE) && ((int'(wd_q) + 1) == TIMEOUT_CYC);
        if (state_d != state_q || state_q == ST_IDLE) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end
        tmo_d = wd_expired | (tmo_q & ~err_clr);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        pend_nz = (pend_q != '0);
        launch  = (state_q == ST_IDLE) && (sync_done_pulse || pend_nz);
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_d = ST_RELEASE;
                    req_d   = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
`ifdef SIG_S2A_TIMEOUT_EN
        if (wd_expired) begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
        end
`endif
    end

    // A pulse taken straight into an empty-queue launch never touches the counter.
    always_comb begin
        dec        = launch && pend_nz;
        pulse_held = sync_done_pulse && !(launch && !pend_nz);
        pend_d     = pend_q;
        ovf_set    = 1'b0;
        if (pulse_held && !dec) begin
            if (pend_q == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (dec && !pulse_held) begin
            pend_d = pend_q - 1'b1;
        end
        ovf_d = ovf_set | (ovf_q & ~err_clr);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign async_done_req = req_q;
    assign pend_cnt       = pend_q;
    assign busy           = (state_q != ST_IDLE);
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_sig_sync2async.sv
// Self-checking bench for sig_sync2async: two instances (4-bit and 2-bit
// queue) checked against an event-level reference model kept in the bench.
`timescale 1ns/1ps
module tb_sig_sync2async;

    localparam int STAGES = 2;
    localparam int TMO    = 16;
    localparam int W0     = 4;
    localparam int W1     = 2;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [1:0]    pulse_v = '0;
    logic [1:0]    ack_v   = '0;
    logic [1:0]    clr_v   = '0;
    logic [1:0]    req_o;
    logic [1:0]    busy_o;
    logic [1:0]    ovf_o;
    logic [1:0]    tmo_o;
    logic [W0-1:0] pend0;
    logic [W1-1:0] pend1;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model: phase 0 idle, 1 waiting ack high, 2 waiting ack low
    int m_phase [2];
    int m_pend  [2];
    int m_ovf   [2];
    int m_tmo   [2];
    int m_wd    [2];
    int m_max   [2];
    int m_hist  [2][STAGES];

    // foreign-domain responder: echoes req after ack_delay cycles, -1 = never
    int ack_delay [2];
    int ack_cnt   [2];

    always #5 sys_clk = ~sys_clk;

    sig_sync2async #(.CNT_W(W0), .SYNC_STAGES(STAGES), .TIMEOUT_CYC(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sync_done_pulse(pulse_v[0]),
        .async_done_ack(ack_v[0]), .err_clr(clr_v[0]), .async_done_req(req_o[0]),
        .pend_cnt(pend0), .busy(busy_o[0]), .overflow(ovf_o[0]), .timeout_err(tmo_o[0])
    );

    sig_sync2async #(.CNT_W(W1), .SYNC_STAGES(STAGES), .TIMEOUT_CYC(TMO)) dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sync_done_pulse(pulse_v[1]),
        .async_done_ack(ack_v[1]), .err_clr(clr_v[1]), .async_done_req(req_o[1]),
        .pend_cnt(pend1), .busy(busy_o[1]), .overflow(ovf_o[1]), .timeout_err(tmo_o[1])
    );

    function automatic logic [31:0] pend_of(input int k);
        return (k == 0) ? 32'(pend0) : 32'(pend1);
    endfunction

    task automatic model_step(input int k);
        int acks;
        int launch;
        int direct;
        int dec;
        int np;
        int ovf_set;
        int tmo_set;
        int nphase;
        if (sys_rst) begin
            m_phase[k] = 0; m_pend[k] = 0; m_ovf[k] = 0; m_tmo[k] = 0; m_wd[k] = 0;
            for (int i = 0; i < STAGES; i++) m_hist[k][i] = 0;
            return;
        end
        acks = m_hist[k][STAGES-1];
        for (int i = STAGES - 1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
        m_hist[k][0] = int'(ack_v[k]);
        launch  = (m_phase[k] == 0 && (pulse_v[k] == 1'b1 || m_pend[k] > 0)) ? 1 : 0;
        direct  = (launch == 1 && m_pend[k] == 0) ? 1 : 0;
        dec     = (launch == 1 && m_pend[k] > 0) ? 1 : 0;
        np      = m_pend[k] + ((pulse_v[k] == 1'b1 && direct == 0) ? 1 : 0) - dec;
        ovf_set = (np > m_max[k]) ? 1 : 0;
        if (ovf_set == 1) np = m_max[k];
        nphase = m_phase[k];
        if (m_phase[k] == 0 && launch == 1) nphase = 1;
        if (m_phase[k] == 1 && acks == 1)   nphase = 2;
        if (m_phase[k] == 2 && acks == 0)   nphase = 0;
        tmo_set = 0;
`ifdef SIG_S2A_TIMEOUT_EN
        if (m_phase[k] != 0) begin
            m_wd[k] = m_wd[k] + 1;
            if (m_wd[k] >= TMO) begin
                nphase  = 0;
                tmo_set = 1;
            end
        end
        if (nphase != m_phase[k] || nphase == 0) m_wd[k] = 0;
`endif
        m_ovf[k]   = (ovf_set == 1 || (m_ovf[k] == 1 && clr_v[k] == 1'b0)) ? 1 : 0;
        m_tmo[k]   = (tmo_set == 1 || (m_tmo[k] == 1 && clr_v[k] == 1'b0)) ? 1 : 0;
        m_pend[k]  = np;
        m_phase[k] = nphase;
    endtask

    task automatic respond(input int k);
        if (ack_delay[k] < 0) return;
        if (req_o[k] !== ack_v[k]) begin
            ack_cnt[k] = ack_cnt[k] + 1;
            if (ack_cnt[k] >= ack_delay[k]) begin
                ack_v[k]   = req_o[k];
                ack_cnt[k] = 0;
            end
        end else begin
            ack_cnt[k] = 0;
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        for (int k = 0; k < 2; k++) respond(k);
    endtask

    task automatic do_reset();
        pulse_v = '0; clr_v = '0; ack_v = '0;
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic drain(input int k, input int bound, output bit done);
        done = 1'b0;
        for (int c = 0; c < bound; c++) begin
            tick();
            if (busy_o[k] === 1'b0 && pend_of(k) == 0) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        ack_delay[0] = 3; ack_delay[1] = 3;
        pulse_v = 2'b11; ack_v = '0; clr_v = '0; sys_rst = 1'b1;
        tick();
        pulse_v = '0;
        tick();
        sys_rst = 1'b0;
        tests_run++; if (req_o !== 2'b00) begin tests_failed++; $display("FAIL reset_req got %b want 00", req_o); end
        tests_run++; if (busy_o !== 2'b00) begin tests_failed++; $display("FAIL reset_busy got %b want 00", busy_o); end
        tests_run++; if (pend0 !== 4'd0 || pend1 !== 2'd0) begin tests_failed++; $display("FAIL reset_pend got %0d/%0d want 0/0", pend0, pend1); end
        tests_run++; if (ovf_o !== 2'b00 || tmo_o !== 2'b00) begin tests_failed++; $display("FAIL reset_flags got ovf %b tmo %b want 00 00", ovf_o, tmo_o); end
        tick();
        tests_run++; if (req_o !== 2'b00 || busy_o !== 2'b00) begin tests_failed++; $display("FAIL reset_pulse_lost got req %b busy %b want 00 00", req_o, busy_o); end
    endtask

    task automatic test_single();
        int rises;
        int max_pend;
        logic prev;
        ack_delay[0] = 3;
        do_reset();
        for (int c = 0; c < 10; c++) tick();
        pulse_v[0] = 1'b1;
        tick();
        pulse_v[0] = 1'b0;
        tests_run++; if (req_o[0] !== 1'b1) begin tests_failed++; $display("FAIL single_latency got req %b want 1", req_o[0]); end
        tests_run++; if (pend0 !== 4'd0) begin tests_failed++; $display("FAIL single_no_queue got pend %0d want 0", pend0); end
        rises = 0; max_pend = 0; prev = req_o[0];
        for (int c = 0; c < 40; c++) begin
            tick();
            if (req_o[0] === 1'b1 && prev === 1'b0) rises++;
            prev = req_o[0];
            if (int'(pend0) > max_pend) max_pend = int'(pend0);
            tests_run++; if (busy_o[0] !== 1'(m_phase[0] != 0)) begin tests_failed++; $display("FAIL single_busy c%0d got %b want %b", c, busy_o[0], m_phase[0] != 0); end
        end
        tests_run++; if (rises != 0 || max_pend != 0) begin tests_failed++; $display("FAIL single_handshake got rises %0d pend %0d want 0 0", rises, max_pend); end
        tests_run++; if (busy_o[0] !== 1'b0 || req_o[0] !== 1'b0) begin tests_failed++; $display("FAIL single_end got busy %b req %b want 0 0", busy_o[0], req_o[0]); end
    endtask

    task automatic test_burst();
        int rises;
        int max_pend;
        logic prev;
        bit done;
        ack_delay[0] = 20;
        do_reset();
        rises = 0; max_pend = 0; prev = 1'b0; done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            pulse_v[0] = 1'b1;
            tick();
            if (req_o[0] === 1'b1 && prev === 1'b0) rises++;
            prev = req_o[0];
            if (int'(pend0) > max_pend) max_pend = int'(pend0);
        end
        pulse_v[0] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (req_o[0] === 1'b1 && prev === 1'b0) rises++;
            prev = req_o[0];
            if (int'(pend0) > max_pend) max_pend = int'(pend0);
            tests_run++; if (pend_of(0) !== m_pend[0]) begin tests_failed++; $display("FAIL burst_pend c%0d got %0d want %0d", c, pend0, m_pend[0]); end
            if (busy_o[0] === 1'b0 && pend0 === 4'd0) begin done = 1'b1; break; end
        end
        tests_run++; if (!done) begin tests_failed++; $display("FAIL burst_timeout got busy %b want 0 within bound", busy_o[0]); end
        tests_run++; if (max_pend != 4) begin tests_failed++; $display("FAIL burst_peak got %0d want 4", max_pend); end
        tests_run++; if (rises != 5) begin tests_failed++; $display("FAIL burst_handshakes got %0d want 5", rises); end
        tests_run++; if (pend0 !== 4'd0) begin tests_failed++; $display("FAIL burst_final_pend got %0d want 0", pend0); end
    endtask

    task automatic test_overflow();
        bit done;
        ack_delay[1] = -1;
        do_reset();
        pulse_v[1] = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        pulse_v[1] = 1'b0;
        tests_run++; if (pend1 !== 2'd3) begin tests_failed++; $display("FAIL ovf_saturate got %0d want 3", pend1); end
        tests_run++; if (ovf_o[1] !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b want 1", ovf_o[1]); end
        pulse_v[1] = 1'b1; clr_v[1] = 1'b1;
        tick();
        pulse_v[1] = 1'b0;
        tests_run++; if (ovf_o[1] !== 1'b1) begin tests_failed++; $display("FAIL ovf_set_wins got %b want 1", ovf_o[1]); end
        tick();
        clr_v[1] = 1'b0;
        tests_run++; if (ovf_o[1] !== 1'b0 || pend1 !== 2'd3) begin tests_failed++; $display("FAIL ovf_clear got ovf %b pend %0d want 0 3", ovf_o[1], pend1); end
        ack_delay[1] = 2;
        drain(1, 300, done);
        tests_run++; if (!done || pend1 !== 2'd0) begin tests_failed++; $display("FAIL ovf_drain got pend %0d busy %b want 0 0", pend1, busy_o[1]); end
    endtask

    task automatic test_same_cycle();
        bit found;
        bit done;
        ack_delay[0] = -1;
        do_reset();
        pulse_v[0] = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        pulse_v[0] = 1'b0;
        tests_run++; if (pend0 !== 4'd2) begin tests_failed++; $display("FAIL same_setup got %0d want 2", pend0); end
        ack_delay[0] = 2;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (busy_o[0] === 1'b0) begin found = 1'b1; break; end
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL same_idle_wait got busy %b want 0 within bound", busy_o[0]); end
        pulse_v[0] = 1'b1;
        tick();
        pulse_v[0] = 1'b0;
        tests_run++; if (pend0 !== 4'd2) begin tests_failed++; $display("FAIL same_cycle_pend got %0d want 2", pend0); end
        tests_run++; if (req_o[0] !== 1'b1) begin tests_failed++; $display("FAIL same_cycle_req got %b want 1", req_o[0]); end
        drain(0, 400, done);
        tests_run++; if (!done) begin tests_failed++; $display("FAIL same_drain got pend %0d want 0", pend0); end
    endtask

    task automatic test_reset_mid();
        ack_delay[0] = -1;
        do_reset();
        pulse_v[0] = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        pulse_v[0] = 1'b0;
        tick();
        tests_run++; if (req_o[0] !== 1'b1 || pend0 !== 4'd2) begin tests_failed++; $display("FAIL rstmid_setup got req %b pend %0d want 1 2", req_o[0], pend0); end
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        tests_run++; if (req_o[0] !== 1'b0 || pend0 !== 4'd0 || busy_o[0] !== 1'b0) begin tests_failed++; $display("FAIL rstmid_edge got req %b pend %0d busy %b want 0 0 0", req_o[0], pend0, busy_o[0]); end
        ack_v[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 6) ack_v[0] = 1'b0;
            tick();
            tests_run++; if (busy_o[0] !== 1'b0 || req_o[0] !== 1'b0) begin tests_failed++; $display("FAIL rstmid_spurious c%0d got busy %b req %b want 0 0", c, busy_o[0], req_o[0]); end
        end
    endtask

    task automatic test_timeout();
        bit done;
        ack_delay[0] = -1;
        do_reset();
        pulse_v[0] = 1'b1;
        tick();
        pulse_v[0] = 1'b0;
`ifdef SIG_S2A_TIMEOUT_EN
        for (int c = 1; c < TMO; c++) begin
            tick();
            tests_run++; if (req_o[0] !== 1'b1) begin tests_failed++; $display("FAIL tmo_hold c%0d got %b want 1", c, req_o[0]); end
        end
        tick();
        tests_run++; if (req_o[0] !== 1'b0 || timeout_flag(0) !== 1'b1 || busy_o[0] !== 1'b0) begin tests_failed++; $display("FAIL tmo_expire got req %b tmo %b busy %b want 0 1 0", req_o[0], tmo_o[0], busy_o[0]); end
        clr_v[0] = 1'b1;
        tick();
        clr_v[0] = 1'b0;
        tests_run++; if (tmo_o[0] !== 1'b0) begin tests_failed++; $display("FAIL tmo_clear got %b want 0", tmo_o[0]); end
`else
        for (int c = 0; c < 40; c++) begin
            tick();
            tests_run++; if (req_o[0] !== 1'b1 || tmo_o[0] !== 1'b0) begin tests_failed++; $display("FAIL notmo_hold c%0d got req %b tmo %b want 1 0", c, req_o[0], tmo_o[0]); end
        end
`endif
        ack_delay[0] = 2;
        drain(0, 100, done);
        tests_run++; if (!done) begin tests_failed++; $display("FAIL tmo_recover got busy %b want 0", busy_o[0]); end
    endtask

    function automatic logic timeout_flag(input int k);
        return tmo_o[k];
    endfunction

    task automatic test_random();
        ack_delay[0] = 2; ack_delay[1] = 1;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            sys_rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 2; k++) begin
                pulse_v[k] = ($urandom_range(0, 2) == 0);
                clr_v[k]   = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 19) == 0) ack_delay[k] = int'($urandom_range(0, 6));
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                tests_run++; if (req_o[k] !== 1'(m_phase[k] == 1)) begin tests_failed++; $display("FAIL rand_req[%0d] c%0d got %b want %b", k, c, req_o[k], m_phase[k] == 1); end
                tests_run++; if (busy_o[k] !== 1'(m_phase[k] != 0)) begin tests_failed++; $display("FAIL rand_busy[%0d] c%0d got %b want %b", k, c, busy_o[k], m_phase[k] != 0); end
                tests_run++; if (pend_of(k) !== m_pend[k]) begin tests_failed++; $display("FAIL rand_pend[%0d] c%0d got %0d want %0d", k, c, pend_of(k), m_pend[k]); end
                tests_run++; if (ovf_o[k] !== 1'(m_ovf[k]) || tmo_o[k] !== 1'(m_tmo[k])) begin tests_failed++; $display("FAIL rand_flags[%0d] c%0d got ovf %b tmo %b want %0d %0d", k, c, ovf_o[k], tmo_o[k], m_ovf[k], m_tmo[k]); end
            end
        end
        sys_rst = 1'b0;
        pulse_v = '0;
        clr_v   = '0;
    endtask

    initial begin
        m_max[0] = (1 << W0) - 1;
        m_max[1] = (1 << W1) - 1;
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_pend[k] = 0; m_ovf[k] = 0; m_tmo[k] = 0; m_wd[k] = 0;
            ack_delay[k] = 3; ack_cnt[k] = 0;
            for (int i = 0; i < STAGES; i++) m_hist[k][i] = 0;
        end
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_same_cycle();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
